// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: region encoding, default 640x480@60 timing, region helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vga_pkg;

   typedef enum logic [1:0] {
      REG_ACTIVE = 2'd0,
      REG_FP     = 2'd1,
      REG_SYNC   = 2'd2,
      REG_BP     = 2'd3
   } region_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit DEF_SYNC_POL = 1'b0;

   // Region that follows r in the ACTIVE -> FP -> SYNC -> BP -> ACTIVE ring.
   function automatic region_e region_next(input region_e r);
      region_e nxt;
      case (r)
         REG_ACTIVE: nxt = REG_FP;
         REG_FP:     nxt = REG_SYNC;
         REG_SYNC:   nxt = REG_BP;
         default:    nxt = REG_ACTIVE;
      endcase
      return nxt;
   endfunction

   // Length of region r for an axis described by its four lengths.
   function automatic int region_len(input region_e r, input int act, input int fp,
                                     input int sync, input int bp);
      int len;
      case (r)
         REG_ACTIVE: len = act;
         REG_FP:     len = fp;
         REG_SYNC:   len = sync;
         default:    len = bp;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus between the sync generator and the pixel fetch logic.
// Latency: n/a (wires only).
// Backpressure: none; the strobe paces the generator and outputs are consumed as produced.
interface vga_sync_gen_if
   import vga_pkg::*;
#(
   parameter int XW = $clog2(DEF_H_ACTIVE),
   parameter int YW = $clog2(DEF_V_ACTIVE)
) ();
   logic          pix_strb_i;
   logic          hsync_o;
   logic          vsync_o;
   logic          de_o;
   logic [XW-1:0] x_o;
   logic [YW-1:0] y_o;
   logic          line_start_o;
   logic          frame_start_o;

   // Generator side.
   modport master (
      input  pix_strb_i,
      output hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
   );

   // Consumer side (strobe source plus raster sink).
   modport slave (
      output pix_strb_i,
      input  hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: region ring ACTIVE/FP/SYNC/BP with a position counter inside the region.
// Latency: state updates on the edge where inc_i=1; wrap_o is combinational from state and inc_i.
// Backpressure: none; holds while inc_i=0.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter  int ACTIVE = DEF_H_ACTIVE,
   parameter  int FP     = DEF_H_FP,
   parameter  int SYNC   = DEF_H_SYNC,
   parameter  int BP     = DEF_H_BP,
   localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
   localparam int PW     = $clog2(TOTAL)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          inc_i,
   output region_e       region_o,
   output logic [PW-1:0] pos_o,
   output logic          wrap_o
);

   region_e       region_q, region_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          last_pos;

   // Advance within the region, stepping to the next region on its last position.
   always_comb begin
      region_d = region_q;
      pos_d    = pos_q;
      last_pos = (int'(pos_q) == region_len(region_q, ACTIVE, FP, SYNC, BP) - 1);
      if (inc_i) begin
         if (last_pos) begin
            pos_d    = '0;
            region_d = region_next(region_q);
         end else begin
            pos_d = pos_q + PW'(1);
         end
      end
      wrap_o = inc_i && last_pos && (region_q == REG_BP);
   end

   // Region and position state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         region_q <= REG_ACTIVE;
         pos_q    <= '0;
      end else begin
         region_q <= region_d;
         pos_q    <= pos_d;
      end
   end

   assign region_o = region_q;
   assign pos_o    = pos_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: hsync/vsync, display enable, pixel coordinates and line/frame pulses.
// Latency: one clk from the strobe edge to outputs showing the new position; all outputs registered.
// Backpressure: none; pix_strb_i=0 freezes the raster and the pulses drop to 0.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter  int H_ACTIVE = DEF_H_ACTIVE,
   parameter  int H_FP     = DEF_H_FP,
   parameter  int H_SYNC   = DEF_H_SYNC,
   parameter  int H_BP     = DEF_H_BP,
   parameter  int V_ACTIVE = DEF_V_ACTIVE,
   parameter  int V_FP     = DEF_V_FP,
   parameter  int V_SYNC   = DEF_V_SYNC,
   parameter  int V_BP     = DEF_V_BP,
   parameter  bit SYNC_POL = DEF_SYNC_POL,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL),
   localparam int XW       = $clog2(H_ACTIVE),
   localparam int YW       = $clog2(V_ACTIVE)
) (
   input logic            clk_i,
   input logic            rst_i,
   vga_sync_gen_if.master bus
);

   region_e       h_region, v_region, h_region_n, v_region_n;
   logic [HW-1:0] h_pos, h_pos_n;
   logic [VW-1:0] v_pos, v_pos_n;
   logic          h_wrap, v_wrap;

   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
   ) u_h_axis (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (bus.pix_strb_i),
      .region_o (h_region),
      .pos_o    (h_pos),
      .wrap_o   (h_wrap)
   );

   // The vertical axis steps once per line, on the strobe that leaves horizontal BP.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
   ) u_v_axis (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (h_wrap),
      .region_o (v_region),
      .pos_o    (v_pos),
      .wrap_o   (v_wrap)
   );

   // Position the axes enter at this edge, so the output flops land in step with the counters.
   always_comb begin
      h_region_n = h_region;
      h_pos_n    = h_pos;
      v_region_n = v_region;
      v_pos_n    = v_pos;
      if (bus.pix_strb_i) begin
         if (int'(h_pos) == region_len(h_region, H_ACTIVE, H_FP, H_SYNC, H_BP) - 1) begin
            h_pos_n    = '0;
            h_region_n = region_next(h_region);
         end else begin
            h_pos_n = h_pos + HW'(1);
         end
      end
      if (h_wrap) begin
         if (int'(v_pos) == region_len(v_region, V_ACTIVE, V_FP, V_SYNC, V_BP) - 1) begin
            v_pos_n    = '0;
            v_region_n = region_next(v_region);
         end else begin
            v_pos_n = v_pos + VW'(1);
         end
      end
   end

   // Decode the upcoming position into sync levels, enable, coordinates and start pulses.
   always_comb begin
      de_d          = (h_region_n == REG_ACTIVE) && (v_region_n == REG_ACTIVE);
      hsync_d       = (h_region_n == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_region_n == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      x_d           = de_d ? XW'(h_pos_n) : '0;
      y_d           = de_d ? YW'(v_pos_n) : '0;
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
   end

   // Output registers; reset lands on (0,0) inside the active area with no pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         de_q          <= 1'b1;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.hsync_o       = hsync_q;
   assign bus.vsync_o       = vsync_q;
   assign bus.de_o          = de_q;
   assign bus.x_o           = x_q;
   assign bus.y_o           = y_q;
   assign bus.line_start_o  = line_start_q;
   assign bus.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (active-low and active-high sync) against a raster model.
// Latency: model expects outputs one clk after each strobe edge.
// Backpressure: n/a.
module tb_vga_sync_gen;
   import vga_pkg::*;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int XW = $clog2(HA);
   localparam int YW = $clog2(VA);
   localparam int OW = 5 + XW + YW;

   logic clk = 1'b0;
   logic rst;
   logic strb;

   int vectors    = 0;
   int miscompares = 0;

   // Model: strobes since reset, modulo the frame, plus the pulses due this cycle.
   int n    = 0;
   bit m_ls = 1'b0;
   bit m_fs = 1'b0;

   vga_sync_gen_if #(.XW(XW), .YW(YW)) if0 ();
   vga_sync_gen_if #(.XW(XW), .YW(YW)) if1 ();
   assign if0.pix_strb_i = strb;
   assign if1.pix_strb_i = strb;

   vga_sync_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
   ) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));

   vga_sync_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
   ) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

   always #5 clk = ~clk;

   // Expected output word {hsync, vsync, de, x, y, line_start, frame_start} from the model position.
   function automatic logic [OW-1:0] exp_vec(input bit pol);
      int hx, vy;
      bit de, hs_in, vs_in;
      logic [XW-1:0] xv;
      logic [YW-1:0] yv;
      hx    = n % HT;
      vy    = n / HT;
      de    = (hx < HA) && (vy < VA);
      hs_in = (hx >= HA + HF) && (hx < HA + HF + HS);
      vs_in = (vy >= VA + VF) && (vy < VA + VF + VS);
      xv    = de ? hx[XW-1:0] : '0;
      yv    = de ? vy[YW-1:0] : '0;
      return {pol ? hs_in : !hs_in, pol ? vs_in : !vs_in, de, xv, yv, m_ls, m_fs};
   endfunction

   function automatic logic [OW-1:0] act(input bit which);
      if (which)
         return {if1.hsync_o, if1.vsync_o, if1.de_o, if1.x_o, if1.y_o,
                 if1.line_start_o, if1.frame_start_o};
      return {if0.hsync_o, if0.vsync_o, if0.de_o, if0.x_o, if0.y_o,
              if0.line_start_o, if0.frame_start_o};
   endfunction

   // One clk: apply inputs, take the edge, advance the model, settle away from the edge.
   task automatic step(input bit s, input bit r);
      strb = s;
      rst  = r;
      @(posedge clk);
      if (r) begin
         n = 0; m_ls = 1'b0; m_fs = 1'b0;
      end else if (s) begin
         n    = (n + 1) % (HT * VT);
         m_ls = (n % HT == 0);
         m_fs = (n == 0);
      end else begin
         m_ls = 1'b0; m_fs = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom_range(0, 1)), 1'b1);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act(d[0]) !== exp_vec(d[0])) begin
               miscompares++;
               $display("FAIL reset pol%0d cyc=%0d got=%b want=%b", d, i, act(d[0]), exp_vec(d[0]));
            end
         end
      end
   endtask

   task automatic test_every_clk();
      int hlow, ls_cnt;
      hlow = 0; ls_cnt = 0;
      step(1'b0, 1'b1);
      for (int i = 0; i < 3 * HT; i++) begin
         step(1'b1, 1'b0);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act(d[0]) !== exp_vec(d[0])) begin
               miscompares++;
               $display("FAIL every_clk pol%0d cyc=%0d got=%b want=%b", d, i, act(d[0]), exp_vec(d[0]));
            end
         end
         if (if0.hsync_o === 1'b0) hlow++;
         if (if0.line_start_o === 1'b1) ls_cnt++;
      end
      vectors++;
      if (hlow !== 3 * HS) begin
         miscompares++;
         $display("FAIL every_clk_hsync_low got=%0d want=%0d", hlow, 3 * HS);
      end
      vectors++;
      if (ls_cnt !== 3) begin
         miscompares++;
         $display("FAIL every_clk_line_pulses got=%0d want=3", ls_cnt);
      end
   endtask

   task automatic test_every_3rd();
      int last_ls, ls_cnt;
      last_ls = -1; ls_cnt = 0;
      step(1'b0, 1'b1);
      for (int i = 0; i < 9 * HT; i++) begin
         step(i % 3 == 2, 1'b0);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act(d[0]) !== exp_vec(d[0])) begin
               miscompares++;
               $display("FAIL every_3rd pol%0d cyc=%0d got=%b want=%b", d, i, act(d[0]), exp_vec(d[0]));
            end
         end
         if (if0.line_start_o === 1'b1) begin
            if (last_ls >= 0) begin
               vectors++;
               if (i - last_ls !== 3 * HT) begin
                  miscompares++;
                  $display("FAIL every_3rd_line_period got=%0d want=%0d", i - last_ls, 3 * HT);
               end
            end
            last_ls = i;
            ls_cnt++;
         end
      end
      vectors++;
      if (ls_cnt !== 3) begin
         miscompares++;
         $display("FAIL every_3rd_line_pulses got=%0d want=3", ls_cnt);
      end
   endtask

   task automatic test_full_frame();
      int vlow0, vhigh1, fs_cnt, ymax;
      vlow0 = 0; vhigh1 = 0; fs_cnt = 0; ymax = 0;
      step(1'b0, 1'b1);
      for (int i = 0; i < HT * VT + 2; i++) begin
         step(1'b1, 1'b0);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act(d[0]) !== exp_vec(d[0])) begin
               miscompares++;
               $display("FAIL frame pol%0d cyc=%0d got=%b want=%b", d, i, act(d[0]), exp_vec(d[0]));
            end
         end
         if (if0.vsync_o === 1'b0) vlow0++;
         if (if1.vsync_o === 1'b1) vhigh1++;
         if (if0.frame_start_o === 1'b1) fs_cnt++;
         if (if0.de_o === 1'b1 && int'(if0.y_o) > ymax) ymax = int'(if0.y_o);
      end
      vectors++;
      if (vlow0 !== VS * HT) begin
         miscompares++;
         $display("FAIL frame_vsync_low got=%0d want=%0d", vlow0, VS * HT);
      end
      vectors++;
      if (vhigh1 !== VS * HT) begin
         miscompares++;
         $display("FAIL frame_vsync_high_pol1 got=%0d want=%0d", vhigh1, VS * HT);
      end
      vectors++;
      if (fs_cnt !== 1) begin
         miscompares++;
         $display("FAIL frame_pulses got=%0d want=1", fs_cnt);
      end
      vectors++;
      if (ymax !== VA - 1) begin
         miscompares++;
         $display("FAIL frame_ymax got=%0d want=%0d", ymax, VA - 1);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1);
      for (int i = 0; i < 2 * HT + 3; i++) step(1'b1, 1'b0);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (act(d[0]) !== exp_vec(d[0])) begin
            miscompares++;
            $display("FAIL reset_mid_pre pol%0d got=%b want=%b", d, act(d[0]), exp_vec(d[0]));
         end
      end
      step(1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (act(d[0]) !== exp_vec(d[0])) begin
            miscompares++;
            $display("FAIL reset_mid_post pol%0d got=%b want=%b", d, act(d[0]), exp_vec(d[0]));
         end
      end
      vectors++;
      if ({if0.line_start_o, if0.frame_start_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_mid_pulse got=%b want=00", {if0.line_start_o, if0.frame_start_o});
      end
   endtask

   task automatic test_idle();
      step(1'b0, 1'b1);
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b0);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act(d[0]) !== exp_vec(d[0])) begin
               miscompares++;
               $display("FAIL idle pol%0d cyc=%0d got=%b want=%b", d, i, act(d[0]), exp_vec(d[0]));
            end
         end
      end
   endtask

   task automatic test_random();
      bit s, r;
      step(1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 127) == 0);
         step(s, r);
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if (act(d[0]) !== exp_vec(d[0])) begin
               miscompares++;
               $display("FAIL random pol%0d cyc=%0d got=%b want=%b", d, i, act(d[0]), exp_vec(d[0]));
            end
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      strb = 1'b0;
      test_reset();
      test_every_clk();
      test_every_3rd();
      test_full_frame();
      test_reset_mid();
      test_idle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
